// File: rtl/ram_param_pkg.sv
// Shared types and constants for the parametrised scratch RAM.
// Holds the clear FSM state enum, default sizes and the parity helper.
package ram_param_pkg;

  localparam int DEF_DATA_W = 16;
  localparam int DEF_ADDR_W = 6;
  localparam int DEF_DEPTH  = 64;
  localparam int PAR_MAX_W  = 64;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_CLEAR = 1'b1
  } state_t;

  // Even-parity bit: makes the XOR of data plus bit zero.
  function automatic logic parity(
    input logic [PAR_MAX_W-1:0] d
  );
    return ^d;
  endfunction

endpackage

// File: rtl/ram_param_clr_seq.sv
// Clear sequencer: walks every word once after reset or on clr.
// Ports: clk, rst_n, clr in; clr_we, clr_addr, busy out.
module ram_param_clr_seq
  import ram_param_pkg::*;
#(
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int DEPTH  = DEF_DEPTH
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              clr,
  output logic              clr_we,
  output logic [ADDR_W-1:0] clr_addr,
  output logic              busy
);

  localparam logic [ADDR_W-1:0] LAST =
    ADDR_W'(DEPTH - 1);

  state_t            state, state_nx;
  logic [ADDR_W-1:0] cnt, cnt_nx;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= ST_CLEAR;
      cnt   <= '0;
    end else begin
      state <= state_nx;
      cnt   <= cnt_nx;
    end
  end

  always_comb begin
    state_nx = state;
    cnt_nx   = cnt;
    unique case (state)
      ST_CLEAR: begin
        if (cnt == LAST) begin
          state_nx = ST_IDLE;
          cnt_nx   = '0;
        end else begin
          cnt_nx = cnt + 1'b1;
        end
      end
      ST_IDLE: begin
        if (clr) begin
          state_nx = ST_CLEAR;
          cnt_nx   = '0;
        end
      end
      default: begin
        state_nx = ST_CLEAR;
        cnt_nx   = '0;
      end
    endcase
  end

  assign busy     = (state == ST_CLEAR);
  assign clr_we   = busy;
  assign clr_addr = cnt;

endmodule

// File: rtl/ram_param.sv
// Single-port sync RAM, registered read, hardware clear after reset/clr.
// Ports: clk rst_n clr en we addr wdata -> rdata rvalid oor busy [perr].
// Optional macro RAM_PARITY_EN adds per-word even parity and perr.
module ram_param
  import ram_param_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int DEPTH  = DEF_DEPTH
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              clr,
  input  logic              en,
  input  logic              we,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] wdata,
  output logic [DATA_W-1:0] rdata,
  output logic              rvalid,
  output logic              oor,
  output logic              busy
`ifdef RAM_PARITY_EN
  ,
  output logic              perr
`endif
);

`ifdef RAM_PARITY_EN
  localparam int MW = DATA_W + 1;
`else
  localparam int MW = DATA_W;
`endif

  localparam logic [ADDR_W:0] DEPTH_V =
    (ADDR_W+1)'(DEPTH);

  logic              clr_we;
  logic [ADDR_W-1:0] clr_addr;
  logic [MW-1:0]     mem [DEPTH];
  logic [MW-1:0]     wword;
  logic [MW-1:0]     rword;
  logic              inr;
  logic              acc;
  logic              rd;

  ram_param_clr_seq #(
    .ADDR_W (ADDR_W),
    .DEPTH  (DEPTH)
  ) u_seq (
    .clk      (clk),
    .rst_n    (rst_n),
    .clr      (clr),
    .clr_we   (clr_we),
    .clr_addr (clr_addr),
    .busy     (busy)
  );

  assign inr = ({1'b0, addr} < DEPTH_V);
  assign acc = en && !busy;
  assign rd  = acc && !we;

`ifdef RAM_PARITY_EN
  assign wword = {parity(PAR_MAX_W'(wdata)), wdata};
`else
  assign wword = wdata;
`endif

  assign rword = mem[addr];

  // Storage has no reset; the clear walk defines it.
  always_ff @(posedge clk) begin
    if (clr_we)
      mem[clr_addr] <= '0;
    else if (acc && we && inr)
      mem[addr] <= wword;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rdata  <= '0;
      rvalid <= 1'b0;
      oor    <= 1'b0;
    end else begin
      rvalid <= rd;
      oor    <= acc && !inr;
      if (rd)
        rdata <= inr ? rword[DATA_W-1:0] : '0;
    end
  end

`ifdef RAM_PARITY_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      perr <= 1'b0;
    else
      perr <= rd && inr &&
        (parity(PAR_MAX_W'(rword[DATA_W-1:0]))
         != rword[DATA_W]);
  end
`endif

endmodule

// File: tb/tb_ram_param.sv
// Directed bench for ram_param: default instance plus a DEPTH=40 one.
// Vector table for the access path, hand sequences for clear/reset.
module tb_ram_param;

  logic        clk = 1'b0;
  logic        rst_n, clr, en, we;
  logic [5:0]  addr;
  logic [15:0] wdata;
  logic [15:0] rdata, rdata_b;
  logic        rvalid, oor, busy;
  logic        rvalid_b, oor_b, busy_b;
`ifdef RAM_PARITY_EN
  logic        perr, perr_b;
`endif

  int pass_cnt = 0;
  int total    = 0;

  always #5 clk = ~clk;

  ram_param u_dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .clr    (clr),
    .en     (en),
    .we     (we),
    .addr   (addr),
    .wdata  (wdata),
    .rdata  (rdata),
    .rvalid (rvalid),
    .oor    (oor),
    .busy   (busy)
`ifdef RAM_PARITY_EN
    ,
    .perr   (perr)
`endif
  );

  ram_param #(
    .DATA_W (16),
    .ADDR_W (6),
    .DEPTH  (40)
  ) u_d40 (
    .clk    (clk),
    .rst_n  (rst_n),
    .clr    (clr),
    .en     (en),
    .we     (we),
    .addr   (addr),
    .wdata  (wdata),
    .rdata  (rdata_b),
    .rvalid (rvalid_b),
    .oor    (oor_b),
    .busy   (busy_b)
`ifdef RAM_PARITY_EN
    ,
    .perr   (perr_b)
`endif
  );

  typedef struct {
    logic        en;
    logic        we;
    logic [5:0]  addr;
    logic [15:0] wdata;
    logic        rv;
    logic [15:0] rd;
    logic        oo;
    logic        rv_b;
    logic [15:0] rd_b;
    logic        oo_b;
  } vec_t;

  vec_t tbl [16];

  function automatic vec_t mk(
    input logic e, input logic w,
    input logic [5:0] a, input logic [15:0] d,
    input logic rv, input logic [15:0] rdv,
    input logic oo,
    input logic rvb, input logic [15:0] rdb,
    input logic oob
  );
    vec_t v;
    v.en = e; v.we = w; v.addr = a; v.wdata = d;
    v.rv = rv; v.rd = rdv; v.oo = oo;
    v.rv_b = rvb; v.rd_b = rdb; v.oo_b = oob;
    return v;
  endfunction

  task automatic chk(
    input string nm,
    input logic [31:0] act,
    input logic [31:0] exp
  );
    total++;
    if (act === exp)
      pass_cnt++;
    else
      $display("FAIL %s: got %0h expected %0h",
               nm, act, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(
    input logic e, input logic w,
    input logic [5:0] a, input logic [15:0] d
  );
    en = e; we = w; addr = a; wdata = d;
  endtask

  // Counts edges until busy falls; optionally hammers the port
  // with reads, one write to an already-cleared word and a clr.
  task automatic wait_clear(
    input int exp_n, input int exp_nb,
    input logic drv
  );
    int n  = 0;
    int nb = 0;
    do begin
      tick();
      n++;
      if (!busy_b && nb == 0) nb = n;
      if (drv) begin
        chk("busy_rvalid", 32'(rvalid), 32'd0);
        chk("busy_oor", 32'(oor), 32'd0);
        clr = (n == 30);
        drive(1'b1, (n == 10),
              (n == 10) ? 6'd2 : 6'(n), 16'hBEEF);
      end
    end while (busy && n < 200);
    drive(1'b0, 1'b0, 6'd0, 16'h0);
    clr = 1'b0;
    chk("busy_len", 32'(n), 32'(exp_n));
    chk("busy_len_d40", 32'(nb), 32'(exp_nb));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: time limit expired");
    $fatal(1, "timeout");
  end

  initial begin
    tbl[0]  = mk(1'b1, 1'b0, 6'd0,  16'h0,
                 1'b1, 16'h0,    1'b0, 1'b1, 16'h0,    1'b0);
    tbl[1]  = mk(1'b1, 1'b0, 6'd31, 16'h0,
                 1'b1, 16'h0,    1'b0, 1'b1, 16'h0,    1'b0);
    tbl[2]  = mk(1'b1, 1'b0, 6'd63, 16'h0,
                 1'b1, 16'h0,    1'b0, 1'b1, 16'h0,    1'b1);
    tbl[3]  = mk(1'b0, 1'b0, 6'd0,  16'h0,
                 1'b0, 16'h0,    1'b0, 1'b0, 16'h0,    1'b0);
    tbl[4]  = mk(1'b1, 1'b1, 6'd5,  16'hA5A5,
                 1'b0, 16'h0,    1'b0, 1'b0, 16'h0,    1'b0);
    tbl[5]  = mk(1'b1, 1'b1, 6'd6,  16'h1234,
                 1'b0, 16'h0,    1'b0, 1'b0, 16'h0,    1'b0);
    tbl[6]  = mk(1'b1, 1'b0, 6'd5,  16'h0,
                 1'b1, 16'hA5A5, 1'b0, 1'b1, 16'hA5A5, 1'b0);
    tbl[7]  = mk(1'b1, 1'b0, 6'd6,  16'h0,
                 1'b1, 16'h1234, 1'b0, 1'b1, 16'h1234, 1'b0);
    tbl[8]  = mk(1'b0, 1'b0, 6'd0,  16'h0,
                 1'b0, 16'h1234, 1'b0, 1'b0, 16'h1234, 1'b0);
    tbl[9]  = mk(1'b1, 1'b1, 6'd5,  16'h5A5A,
                 1'b0, 16'h1234, 1'b0, 1'b0, 16'h1234, 1'b0);
    tbl[10] = mk(1'b1, 1'b0, 6'd5,  16'h0,
                 1'b1, 16'h5A5A, 1'b0, 1'b1, 16'h5A5A, 1'b0);
    tbl[11] = mk(1'b0, 1'b0, 6'd0,  16'h0,
                 1'b0, 16'h5A5A, 1'b0, 1'b0, 16'h5A5A, 1'b0);
    tbl[12] = mk(1'b1, 1'b1, 6'd45, 16'hFFFF,
                 1'b0, 16'h5A5A, 1'b0, 1'b0, 16'h5A5A, 1'b1);
    tbl[13] = mk(1'b1, 1'b0, 6'd45, 16'h0,
                 1'b1, 16'hFFFF, 1'b0, 1'b1, 16'h0,    1'b1);
    tbl[14] = mk(1'b1, 1'b0, 6'd5,  16'h0,
                 1'b1, 16'h5A5A, 1'b0, 1'b1, 16'h5A5A, 1'b0);
    tbl[15] = mk(1'b0, 1'b0, 6'd0,  16'h0,
                 1'b0, 16'h5A5A, 1'b0, 1'b0, 16'h5A5A, 1'b0);

    rst_n = 1'b0;
    clr   = 1'b0;
    drive(1'b0, 1'b0, 6'd0, 16'h0);
    repeat (3) tick();

    chk("rst_rdata", 32'(rdata), 32'd0);
    chk("rst_rvalid", 32'(rvalid), 32'd0);
    chk("rst_oor", 32'(oor), 32'd0);
    chk("rst_busy", 32'(busy), 32'd1);
    chk("rst_busy_d40", 32'(busy_b), 32'd1);
`ifdef RAM_PARITY_EN
    chk("rst_perr", 32'(perr), 32'd0);
`endif

    rst_n = 1'b1;
    wait_clear(64, 40, 1'b0);

    for (int i = 0; i < 16; i++) begin
      drive(tbl[i].en, tbl[i].we,
            tbl[i].addr, tbl[i].wdata);
      tick();
      chk($sformatf("v%0d_rvalid", i),
          32'(rvalid), 32'(tbl[i].rv));
      chk($sformatf("v%0d_rdata", i),
          32'(rdata), 32'(tbl[i].rd));
      chk($sformatf("v%0d_oor", i),
          32'(oor), 32'(tbl[i].oo));
      chk($sformatf("v%0d_rvalid_d40", i),
          32'(rvalid_b), 32'(tbl[i].rv_b));
      chk($sformatf("v%0d_rdata_d40", i),
          32'(rdata_b), 32'(tbl[i].rd_b));
      chk($sformatf("v%0d_oor_d40", i),
          32'(oor_b), 32'(tbl[i].oo_b));
      chk($sformatf("v%0d_busy", i),
          32'(busy), 32'd0);
    end

    // Fill, then clear on request with traffic during busy.
    for (int i = 0; i < 64; i++) begin
      drive(1'b1, 1'b1, 6'(i), 16'(16'h0100 + i));
      tick();
    end
    drive(1'b1, 1'b0, 6'd63, 16'h0);
    tick();
    chk("fill_rd63", 32'(rdata), 32'h013F);
    chk("fill_rv63", 32'(rvalid), 32'd1);
    drive(1'b0, 1'b0, 6'd0, 16'h0);
    clr = 1'b1;
    tick();
    clr = 1'b0;
    chk("clr_busy", 32'(busy), 32'd1);
    wait_clear(64, 40, 1'b1);
    chk("clr_rdata_hold", 32'(rdata), 32'h013F);
    for (int i = 0; i < 64; i++) begin
      drive(1'b1, 1'b0, 6'(i), 16'h0);
      tick();
      chk($sformatf("zero_rv%0d", i),
          32'(rvalid), 32'd1);
      chk($sformatf("zero_rd%0d", i),
          32'(rdata), 32'd0);
    end
    drive(1'b0, 1'b0, 6'd0, 16'h0);

    // Reset in the middle of a clear walk.
    drive(1'b1, 1'b1, 6'd9, 16'h7777);
    tick();
    drive(1'b1, 1'b0, 6'd9, 16'h0);
    tick();
    chk("pre_rdata", 32'(rdata), 32'h7777);
    drive(1'b0, 1'b0, 6'd0, 16'h0);
    clr = 1'b1;
    tick();
    clr = 1'b0;
    repeat (20) tick();
    chk("mid_busy", 32'(busy), 32'd1);
    chk("mid_rdata", 32'(rdata), 32'h7777);
    rst_n = 1'b0;
    #1;
    chk("arst_rdata", 32'(rdata), 32'd0);
    chk("arst_rvalid", 32'(rvalid), 32'd0);
    chk("arst_oor", 32'(oor), 32'd0);
    chk("arst_busy", 32'(busy), 32'd1);
    #2;
    rst_n = 1'b1;
    wait_clear(64, 40, 1'b0);
    drive(1'b1, 1'b0, 6'd9, 16'h0);
    tick();
    chk("post_rv9", 32'(rvalid), 32'd1);
    chk("post_rd9", 32'(rdata), 32'd0);
    drive(1'b0, 1'b0, 6'd0, 16'h0);
    tick();
    chk("post_rv_drop", 32'(rvalid), 32'd0);

`ifdef RAM_PARITY_EN
    drive(1'b1, 1'b1, 6'd3, 16'h0001);
    tick();
    drive(1'b1, 1'b1, 6'd4, 16'h0003);
    tick();
    drive(1'b0, 1'b0, 6'd0, 16'h0);
    u_dut.mem[3][0] = ~u_dut.mem[3][0];
    drive(1'b1, 1'b0, 6'd3, 16'h0);
    tick();
    chk("par_rv3", 32'(rvalid), 32'd1);
    chk("par_perr3", 32'(perr), 32'd1);
    drive(1'b1, 1'b0, 6'd4, 16'h0);
    tick();
    chk("par_rd4", 32'(rdata), 32'h0003);
    chk("par_perr4", 32'(perr), 32'd0);
    drive(1'b0, 1'b0, 6'd0, 16'h0);
    tick();
`endif

    $display("%0d/%0d checks passed", pass_cnt, total);
    $finish;
  end

endmodule
